button_cmd_encoder: RTL and testbench

Input-side counterpart of the game core: it turns the raw left/right/throw push-buttons into a queue of one-shot movement and throw commands on the button clock domain. Each button input is synchronised and debounced. Left and right get auto-repeat while held. Commands are buffered in a small FIFO and drained through a valid/ready handshake by the game logic, which pops at most one command per buttonclk cycle.

---
 rtl/button_cmd_encoder.sv | 82 ++++++++
 tb/tb_button_cmd_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/button_cmd_encoder.sv
// button_cmd_encoder: debounced left/right/throw buttons with auto-repeat and a command FIFO (buttonclk, reset, enable, *_raw, cmd_ready -> cmd_valid, cmd_code, fifo_count, overflow)
module button_cmd_encoder #(
    parameter int DB_CYCLES     = 2,
    parameter int REPEAT_DELAY  = 6,
    parameter int REPEAT_PERIOD = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          buttonclk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          left_raw,
    input  logic                          right_raw,
    input  logic                          throw_raw,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [1:0]                    cmd_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam logic [DW-1:0] DB_C = DW'(DB_CYCLES);
    localparam logic [HW-1:0] RD_C = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] RL_C = HW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    logic [2:0]    s1, s2, db, db_n, flip;
    logic [DW-1:0] cnt [3];
    logic [HW-1:0] hold [2];
    logic [HW-1:0] hold_n [2];
    logic [1:0]    rep;
    logic          conflict, ev_t, ev_l, ev_r, push, pop;
    logic [1:0]    code;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    assign cmd_valid = |fifo_count;
    assign cmd_code  = cmd_valid ? mem[rp] : 2'b00;
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            flip[i] = (s2[i] != db[i]) && (cnt[i] + 1'b1 == DB_C);
            db_n[i] = db[i] ^ flip[i];
        end
        conflict = db_n[0] & db_n[1];
        for (int i = 0; i < 2; i++) begin
            rep[i]    = enable & ~conflict & db[i] & db_n[i] & (hold[i] + 1'b1 == RD_C);
            hold_n[i] = (enable & ~conflict & db[i] & db_n[i]) ? (rep[i] ? RL_C : hold[i] + 1'b1) : '0;
        end
        ev_t = enable & flip[2] & ~db[2];
        ev_l = enable & ~conflict & ((flip[0] & ~db[0]) | rep[0]);
        ev_r = enable & ~conflict & ((flip[1] & ~db[1]) | rep[1]);
        code = ev_t ? 2'b11 : ev_l ? 2'b01 : ev_r ? 2'b10 : 2'b00;
        pop  = cmd_valid & cmd_ready;
        push = (|code) & ((fifo_count != DEPTH_C) | pop);
    end
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            db         <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
            for (int i = 0; i < 2; i++) hold[i] <= '0;
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            s1 <= {throw_raw, right_raw, left_raw};
            s2 <= s1;
            db <= db_n;
            for (int i = 0; i < 3; i++) cnt[i] <= (s2[i] != db[i] && !flip[i]) ? cnt[i] + 1'b1 : '0;
            for (int i = 0; i < 2; i++) hold[i] <= hold_n[i];
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if ((|code) && !push) overflow <= 1'b1;
        end
    end
    always_ff @(posedge buttonclk) begin
        if (push && !reset) mem[wp] <= code;
    end
endmodule

// File: tb/tb_button_cmd_encoder.sv
// tb_button_cmd_encoder: vector table plus directed sequences, popped commands checked against an expected-code queue
module tb_button_cmd_encoder;
    logic       buttonclk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       left_raw = 1'b0;
    logic       right_raw = 1'b0;
    logic       throw_raw = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [2:0] fifo_count;
    logic       overflow;
    int total = 0;
    int bad = 0;
    int pops = 0;
    logic [1:0] exp_q [$];
    typedef struct {
        logic       l, r, t, en;
        int         cyc;
        int         cnt;
        logic [1:0] code;
    } vec_t;
    vec_t vecs [9];
    button_cmd_encoder dut (
        .buttonclk(buttonclk), .reset(reset), .enable(enable),
        .left_raw(left_raw), .right_raw(right_raw), .throw_raw(throw_raw),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .fifo_count(fifo_count), .overflow(overflow)
    );
    always #5 buttonclk = ~buttonclk;
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge buttonclk);
            #1;
        end
    endtask
    always @(negedge buttonclk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got code %0d expected no command at %0t", cmd_code, $time);
            end else begin
                check("sb_code", int'(cmd_code), int'(exp_q.pop_front()));
            end
        end
    end
    task automatic drain(input string name);
        cmd_ready = 1'b1;
        for (int i = 0; i < 20 && cmd_valid; i++) tick();
        cmd_ready = 1'b0;
        check({name, "_empty"}, int'(cmd_valid), 0);
        check({name, "_code0"}, int'(cmd_code), 0);
        check({name, "_sbq"}, exp_q.size(), 0);
    endtask
    task automatic press_left();
        left_raw = 1'b1;
        tick(4);
        left_raw = 1'b0;
        tick(8);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int p0;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 4, 1, 2'b01};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 4, 1, 2'b10};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 4, 1, 2'b11};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 2'b00};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 4, 1, 2'b11};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 4, 0, 2'b00};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 0, 2'b00};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 4, 1, 2'b11};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 2'b00};
        tick(3);
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_code", int'(cmd_code), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        reset = 1'b0;
        tick(2);
        left_raw = 1'b1;
        tick(3);
        check("lat_valid_e3", int'(cmd_valid), 0);
        tick();
        check("lat_valid_e4", int'(cmd_valid), 1);
        check("lat_code_e4", int'(cmd_code), 1);
        check("lat_count_e4", int'(fifo_count), 1);
        exp_q.push_back(2'b01);
        left_raw = 1'b0;
        tick(8);
        check("hold_code", int'(cmd_code), 1);
        check("hold_count", int'(fifo_count), 1);
        drain("lat");
        for (int v = 0; v < 9; v++) begin
            left_raw = vecs[v].l;
            right_raw = vecs[v].r;
            throw_raw = vecs[v].t;
            enable = vecs[v].en;
            tick(vecs[v].cyc);
            {left_raw, right_raw, throw_raw} = 3'b000;
            tick(8);
            check($sformatf("vec%0d_count", v), int'(fifo_count), vecs[v].cnt);
            check($sformatf("vec%0d_code", v), int'(cmd_code), int'(vecs[v].code));
            if (vecs[v].cnt > 0) exp_q.push_back(vecs[v].code);
            drain($sformatf("vec%0d", v));
            enable = 1'b1;
        end
        p0 = pops;
        cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(2'b10);
        right_raw = 1'b1;
        tick(20);
        right_raw = 1'b0;
        tick(8);
        cmd_ready = 1'b0;
        check("rep_pops", pops - p0, 8);
        check("rep_sbq", exp_q.size(), 0);
        p0 = pops;
        cmd_ready = 1'b1;
        exp_q.push_back(2'b11);
        throw_raw = 1'b1;
        tick(20);
        throw_raw = 1'b0;
        tick(8);
        cmd_ready = 1'b0;
        check("throw_pops", pops - p0, 1);
        for (int i = 0; i < 4; i++) begin
            press_left();
            exp_q.push_back(2'b01);
        end
        check("ovf_pre", int'(overflow), 0);
        press_left();
        check("ovf_count", int'(fifo_count), 4);
        check("ovf_set", int'(overflow), 1);
        drain("ovf");
        check("ovf_sticky", int'(overflow), 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("ovf_reset", int'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            press_left();
            exp_q.push_back(2'b01);
        end
        check("full_count", int'(fifo_count), 4);
        exp_q.push_back(2'b11);
        throw_raw = 1'b1;
        tick(3);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        throw_raw = 1'b0;
        check("pp_count", int'(fifo_count), 4);
        check("pp_ovf", int'(overflow), 0);
        tick(8);
        drain("pp");
        left_raw = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(2);
        check("mid_count", int'(fifo_count), 0);
        check("mid_valid", int'(cmd_valid), 0);
        check("mid_code", int'(cmd_code), 0);
        exp_q.delete();
        reset = 1'b0;
        tick(3);
        check("rel_valid_e3", int'(cmd_valid), 0);
        tick();
        check("rel_valid_e4", int'(cmd_valid), 1);
        check("rel_code_e4", int'(cmd_code), 1);
        exp_q.push_back(2'b01);
        left_raw = 1'b0;
        tick(8);
        drain("rel");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
